// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and FSM state type for the regfile write arbiter
//   NUM_ENTRIES - regfile depth
//   ADDR_W      - regfile address width
//   DATA_W      - regfile data width
//   state_e     - arbiter FSM states (CLEAR zeroes the regfile, RUN arbitrates)
package regfile_pkg;
    localparam int NUM_ENTRIES = 4;
    localparam int ADDR_W = 2;
    localparam int DATA_W = 4;
    typedef enum logic {CLEAR, RUN} state_e;
endpackage

// File: rtl/rr_arb_2.sv
// rr_arb_2: two-input round-robin arbiter with enable
//   clk   - clock
//   rst_n - asynchronous active-low reset (prio returns to client 0)
//   en    - allow grants this cycle
//   req   - request vector, bit i from client i
//   gnt   - one-hot (or zero) grant vector
module rr_arb_2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    logic prio_q, prio_d;

    always_comb begin
        gnt = 2'b00;
        if (en) gnt = (req == 2'b11) ? (prio_q ? 2'b10 : 2'b01) : req;
        // The winner loses priority next time; idle cycles keep the pointer.
        prio_d = gnt[0] ? 1'b1 : (gnt[1] ? 1'b0 : prio_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prio_q <= 1'b0;
        else        prio_q <= prio_d;
    end
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the regfile write port between two clients, zeroing it after reset/clear
//   clk, rst_n           - clock, asynchronous active-low reset
//   clear                - synchronous request to re-zero all entries
//   reqN_val/addr/data   - client N write request
//   reqN_rdy             - client N write accepted this cycle
//   rf_wen/waddr/wdata   - regfile write port
//   init_done            - high once the regfile has been zeroed (RUN)
module regfile_write_arbiter
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              req0_val,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_rdy,
    input  logic              req1_val,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_rdy,
    output logic              rf_wen,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              init_done
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [1:0]        gnt;
    logic              run;

    assign run = (state_q == RUN);

    rr_arb_2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (run && !clear),
        .req   ({req1_val, req0_val}),
        .gnt   (gnt)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!run) begin
            // cnt wraps to 0 naturally after the last entry.
            cnt_d = clear ? '0 : cnt_q + 1'b1;
            if (!clear && cnt_q == ADDR_W'(NUM_ENTRIES - 1)) state_d = RUN;
        end else if (clear) begin
            state_d = CLEAR;
            cnt_d   = '0;
        end
        req0_rdy  = gnt[0];
        req1_rdy  = gnt[1];
        init_done = run;
        rf_wen    = !run || (|gnt);
        rf_waddr  = !run ? cnt_q : gnt[0] ? req0_addr : gnt[1] ? req1_addr : '0;
        // gnt is zero while clearing, so wdata is 0 there as well.
        rf_wdata  = gnt[0] ? req0_data : gnt[1] ? req1_data : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule
